// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and widths used by the MEM stage slice.
package mips_pkg;

    localparam int DATA_W          = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int WORD_ALIGN_BITS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage -> MEM/WB signal bundle.
// The master modport is the upstream pipeline side; the slave modport is the MEM stage.
interface mem_stage_if;
    import mips_pkg::*;

    logic                  reg_write_in;
    logic                  mem_to_reg_in;
    logic                  mem_read_in;
    logic                  mem_write_in;
    logic                  branch_in;
    logic                  zero_in;
    logic [DATA_W-1:0]     branch_target_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [DATA_W-1:0]     read_data2_in;
    logic [REG_ADDR_W-1:0] write_reg_in;

    logic                  pc_src;
    logic [DATA_W-1:0]     branch_target_out;
    logic                  stall;
    logic                  misaligned;
    logic                  reg_write_out;
    logic                  mem_to_reg_out;
    logic [DATA_W-1:0]     mem_read_data_out;
    logic [DATA_W-1:0]     alu_result_out;
    logic [REG_ADDR_W-1:0] write_reg_out;

    modport master (
        output reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in,
               branch_in, zero_in, branch_target_in, alu_result_in,
               read_data2_in, write_reg_in,
        input  pc_src, branch_target_out, stall, misaligned,
               reg_write_out, mem_to_reg_out, mem_read_data_out,
               alu_result_out, write_reg_out
    );

    modport slave (
        input  reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in,
               branch_in, zero_in, branch_target_in, alu_result_in,
               read_data2_in, write_reg_in,
        output pc_src, branch_target_out, stall, misaligned,
               reg_write_out, mem_to_reg_out, mem_read_data_out,
               alu_result_out, write_reg_out
    );

endinterface

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data RAM: synchronous write, combinational read.
// Contents are intentionally not reset.
module data_memory
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[index_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[index_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, wait-stated data memory access with stall,
// and the MEM/WB pipeline register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 0
) (
    input  logic      clk,
    input  logic      reset,
    mem_stage_if.slave bus
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_M1 = (MEM_LATENCY == 0) ? 3'd0 : 3'(MEM_LATENCY - 1);

    mem_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic              access;
    logic              mis_raw;
    logic              valid_acc;
    logic              stall_c;
    logic              commit;
    logic              mem_we;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] rdata;

    logic                  rw_q, rw_d;
    logic                  m2r_q, m2r_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;

    assign access    = bus.mem_read_in | bus.mem_write_in;
    assign mis_raw   = access & (bus.alu_result_in[WORD_ALIGN_BITS-1:0] != '0);
    assign valid_acc = access & ~mis_raw;
    assign index     = bus.alu_result_in[IDX_W+WORD_ALIGN_BITS-1:WORD_ALIGN_BITS];

    // Inputs are held stable by the hazard unit while stalled, so the commit
    // cycle simply uses whatever is presented then.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_acc) begin
                    if (MEM_LATENCY == 0) begin
                        commit = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            stall_c = 1'b0;
            commit  = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign mem_we = commit & bus.mem_write_in & ~mis_raw;

    data_memory #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_dmem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .index_i (index),
        .wdata_i (bus.read_data2_in),
        .rdata_o (rdata)
    );

    // Load data is sampled from the pre-edge array, giving read-before-write.
    always_comb begin
        rw_d    = 1'b0;
        m2r_d   = 1'b0;
        rdata_d = '0;
        alu_d   = '0;
        wreg_d  = '0;
        if (!stall_c) begin
            rw_d    = bus.reg_write_in & ~mis_raw;
            m2r_d   = bus.mem_to_reg_in;
            rdata_d = (bus.mem_read_in & ~mis_raw) ? rdata : '0;
            alu_d   = bus.alu_result_in;
            wreg_d  = bus.write_reg_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rdata_q <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            wreg_q  <= wreg_d;
        end
    end

    assign bus.stall             = stall_c;
    assign bus.misaligned        = mis_raw & ~reset;
    assign bus.pc_src            = bus.branch_in & bus.zero_in & ~stall_c & ~reset;
    assign bus.branch_target_out = bus.branch_target_in;
    assign bus.reg_write_out     = rw_q;
    assign bus.mem_to_reg_out    = m2r_q;
    assign bus.mem_read_data_out = rdata_q;
    assign bus.alu_result_out    = alu_q;
    assign bus.write_reg_out     = wreg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: three instances (latency 0, 2, 3) driven with
// directed vectors; expected MEM/WB values are queued per edge and checked by a monitor.
module tb_mem_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        rd;
        logic        wr;
        logic        br;
        logic        z;
        logic [31:0] tgt;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wreg;
    } ex_t;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } wb_t;

    localparam wb_t BUB = '0;

    logic clk;
    logic rstv  [3];
    ex_t  exv   [3];
    wb_t  act   [3];
    logic stall_a [3];
    logic pc_a    [3];
    logic mis_a   [3];
    logic [31:0] tgt_a [3];

    wb_t q0 [$];
    wb_t q1 [$];
    wb_t q2 [$];

    int checks   = 0;
    int failures = 0;

    mem_stage_if bus [3] ();

    function automatic int lat_of(int g);
        return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : G
        assign bus[g].reg_write_in     = exv[g].rw;
        assign bus[g].mem_to_reg_in    = exv[g].m2r;
        assign bus[g].mem_read_in      = exv[g].rd;
        assign bus[g].mem_write_in     = exv[g].wr;
        assign bus[g].branch_in        = exv[g].br;
        assign bus[g].zero_in          = exv[g].z;
        assign bus[g].branch_target_in = exv[g].tgt;
        assign bus[g].alu_result_in    = exv[g].alu;
        assign bus[g].read_data2_in    = exv[g].wd;
        assign bus[g].write_reg_in     = exv[g].wreg;

        assign act[g]     = '{bus[g].reg_write_out, bus[g].mem_to_reg_out,
                              bus[g].mem_read_data_out, bus[g].alu_result_out,
                              bus[g].write_reg_out};
        assign stall_a[g] = bus[g].stall;
        assign pc_a[g]    = bus[g].pc_src;
        assign mis_a[g]   = bus[g].misaligned;
        assign tgt_a[g]   = bus[g].branch_target_out;

        mem_stage #(
            .DEPTH_WORDS (256),
            .MEM_LATENCY (lat_of(g))
        ) u_dut (
            .clk   (clk),
            .reset (rstv[g]),
            .bus   (bus[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    function automatic ex_t mk(input logic rw, input logic m2r, input logic rd, input logic wr,
                               input logic br, input logic z, input logic [31:0] tgt,
                               input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg);
        ex_t x;
        x = '{rw, m2r, rd, wr, br, z, tgt, alu, wd, wreg};
        return x;
    endfunction

    function automatic wb_t wb(input logic rw, input logic m2r, input logic [31:0] rdata,
                               input logic [31:0] alu, input logic [4:0] wreg);
        wb_t w;
        w = '{rw, m2r, rdata, alu, wreg};
        return w;
    endfunction

    task automatic push(input int d, input wb_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic comb_chk(input int d, input logic es, input logic epc, input logic emis);
        chk($sformatf("d%0d.stall", d), 32'(stall_a[d]), 32'(es));
        chk($sformatf("d%0d.pc_src", d), 32'(pc_a[d]), 32'(epc));
        chk($sformatf("d%0d.misaligned", d), 32'(mis_a[d]), 32'(emis));
        chk($sformatf("d%0d.target", d), tgt_a[d], exv[d].tgt);
    endtask

    // Drive one cycle on instance d, queue the MEM/WB value expected at the
    // coming edge, check combinational outputs, then advance to edge+2.
    task automatic cyc(input int d, input logic r, input ex_t x, input wb_t e,
                       input logic es, input logic epc, input logic emis);
        rstv[d] = r;
        exv[d]  = x;
        push(d, e);
        #1;
        comb_chk(d, es, epc, emis);
        @(posedge clk);
        #2;
    endtask

    task automatic cmp_wb(input int d, input wb_t a, input wb_t e);
        chk($sformatf("d%0d.reg_write_out", d), 32'(a.rw), 32'(e.rw));
        chk($sformatf("d%0d.mem_to_reg_out", d), 32'(a.m2r), 32'(e.m2r));
        chk($sformatf("d%0d.mem_read_data_out", d), a.rdata, e.rdata);
        chk($sformatf("d%0d.alu_result_out", d), a.alu, e.alu);
        chk($sformatf("d%0d.write_reg_out", d), 32'(a.wreg), 32'(e.wreg));
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) cmp_wb(0, act[0], q0.pop_front());
        if (q1.size() > 0) cmp_wb(1, act[1], q1.pop_front());
        if (q2.size() > 0) cmp_wb(2, act[2], q2.pop_front());
    end

    initial begin
        ex_t x;
        // Reset edge on all three; active inputs must not leak through.
        rstv[0] = 1'b1; exv[0] = mk(1, 1, 1, 0, 1, 1, 32'h1234, 32'h1, 0, 5'd3);
        rstv[1] = 1'b1; exv[1] = mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        rstv[2] = 1'b1; exv[2] = mk(0, 0, 0, 1, 0, 0, 0, 32'h40, 32'h5, 0);
        for (int d = 0; d < 3; d++) push(d, BUB);
        #1;
        for (int d = 0; d < 3; d++) comb_chk(d, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;

        // Latency 0: store/load, branch, misaligned, read+write, wrap
        cyc(0, 0, mk(0, 0, 0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0), wb(0, 0, 0, 32'h10, 0), 0, 0, 0);
        cyc(0, 0, mk(1, 1, 1, 0, 0, 0, 0, 32'h10, 0, 8), wb(1, 1, 32'hDEADBEEF, 32'h10, 8), 0, 0, 0);
        cyc(0, 0, mk(1, 0, 0, 0, 1, 1, 32'h00400040, 32'h55, 0, 3), wb(1, 0, 0, 32'h55, 3), 0, 1, 0);
        cyc(0, 0, mk(1, 0, 0, 0, 1, 0, 32'h00400040, 32'h55, 0, 3), wb(1, 0, 0, 32'h55, 3), 0, 0, 0);
        cyc(0, 0, mk(1, 0, 0, 1, 0, 0, 0, 32'h13, 32'h11111111, 5), wb(0, 0, 0, 32'h13, 5), 0, 0, 1);
        cyc(0, 0, mk(1, 1, 1, 0, 0, 0, 0, 32'h12, 0, 7), wb(0, 1, 0, 32'h12, 7), 0, 0, 1);
        cyc(0, 0, mk(1, 1, 1, 0, 0, 0, 0, 32'h10, 0, 9), wb(1, 1, 32'hDEADBEEF, 32'h10, 9), 0, 0, 0);
        cyc(0, 0, mk(1, 1, 1, 1, 0, 0, 0, 32'h10, 32'h77777777, 10), wb(1, 1, 32'hDEADBEEF, 32'h10, 10), 0, 0, 0);
        cyc(0, 0, mk(1, 1, 1, 0, 0, 0, 0, 32'h10, 0, 11), wb(1, 1, 32'h77777777, 32'h10, 11), 0, 0, 0);
        cyc(0, 0, mk(0, 0, 0, 1, 0, 0, 0, 32'h400, 32'hCAFE0001, 0), wb(0, 0, 0, 32'h400, 0), 0, 0, 0);
        cyc(0, 0, mk(1, 1, 1, 0, 0, 0, 0, 32'h000, 0, 2), wb(1, 1, 32'hCAFE0001, 32'h0, 2), 0, 0, 0);
        exv[0] = '0;

        // Latency 2: two stall bubbles per access
        x = mk(0, 0, 0, 1, 0, 0, 0, 32'h20, 32'h12345678, 0);
        cyc(1, 0, x, BUB, 1, 0, 0);
        cyc(1, 0, x, BUB, 1, 0, 0);
        cyc(1, 0, x, wb(0, 0, 0, 32'h20, 0), 0, 0, 0);
        x = mk(1, 1, 1, 0, 1, 1, 32'h00000800, 32'h20, 0, 4);
        cyc(1, 0, x, BUB, 1, 0, 0);
        cyc(1, 0, x, BUB, 1, 0, 0);
        cyc(1, 0, x, wb(1, 1, 32'h12345678, 32'h20, 4), 0, 1, 0);
        cyc(1, 0, mk(1, 0, 0, 0, 0, 0, 0, 32'h99, 0, 12), wb(1, 0, 0, 32'h99, 12), 0, 0, 0);
        exv[1] = '0;

        // Latency 3: reset abandons an in-flight store
        x = mk(0, 0, 0, 1, 0, 0, 0, 32'h40, 32'h0BADF00D, 0);
        cyc(2, 0, x, BUB, 1, 0, 0);
        cyc(2, 0, x, BUB, 1, 0, 0);
        cyc(2, 0, x, BUB, 1, 0, 0);
        cyc(2, 0, x, wb(0, 0, 0, 32'h40, 0), 0, 0, 0);
        x = mk(1, 0, 0, 1, 1, 1, 32'h4, 32'h40, 32'hAAAA5555, 1);
        cyc(2, 0, x, BUB, 1, 0, 0);
        cyc(2, 0, x, BUB, 1, 0, 0);
        cyc(2, 1, x, BUB, 0, 0, 0);
        cyc(2, 0, '0, BUB, 0, 0, 0);
        x = mk(1, 1, 1, 0, 0, 0, 0, 32'h40, 0, 6);
        cyc(2, 0, x, BUB, 1, 0, 0);
        cyc(2, 0, x, BUB, 1, 0, 0);
        cyc(2, 0, x, BUB, 1, 0, 0);
        cyc(2, 0, x, wb(1, 1, 32'h0BADF00D, 32'h40, 6), 0, 0, 0);
        exv[2] = '0;

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Resolves branches from branch/zero/target.
- Performs word loads and stores on an internal data memory with configurable wait-state latency, raising a stall while an access is in flight.
- Registers results into the MEM/WB boundary, which feeds write-back.

Parameters:
DEPTH_WORDS, 256, data memory depth in 32-bit words; power of two.
MEM_LATENCY, 0, extra wait cycles per load or store; range 0..7.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
reg_write_in  input  1  from EX/MEM
mem_to_reg_in  input  1  from EX/MEM
mem_read_in  input  1  load request
mem_write_in  input  1  store request
branch_in  input  1  branch instruction
zero_in  input  1  ALU zero flag
branch_target_in  input  32  branch target address
alu_result_in  input  32  byte address for load/store, or ALU result
read_data2_in  input  32  store data
write_reg_in  input  5  destination register
pc_src  output  1  take branch (combinational)
branch_target_out  output  32  branch_target_in passed through (combinational)
stall  output  1  hold IF/ID/EX and EX/MEM (combinational)
misaligned  output  1  access with alu_result_in[1:0]!=0 (combinational)
reg_write_out  output  1  MEM/WB register
mem_to_reg_out  output  1  MEM/WB register
mem_read_data_out  output  32  MEM/WB register, load data
alu_result_out  output  32  MEM/WB register
write_reg_out  output  5  MEM/WB register

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- While reset is high:
  - All MEM/WB outputs clear to 0 at the edge.
  - FSM goes to IDLE and cnt clears to 0.
  - stall, pc_src and misaligned are forced to 0.
  - Memory contents are NOT cleared.
- Definitions:
  - access = mem_read_in | mem_write_in.
  - index = alu_result_in[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - misaligned = access & (alu_result_in[1:0] != 0).
  - A valid access is access & !misaligned.
- FSM states: IDLE, BUSY; 3-bit counter cnt.
  - IDLE, valid access, MEM_LATENCY>0: stall=1; next state BUSY; cnt <= MEM_LATENCY-1.
  - BUSY, cnt!=0: stall=1; cnt <= cnt-1.
  - BUSY, cnt==0: stall=0; access commits at this edge; next state IDLE.
  - IDLE, valid access, MEM_LATENCY==0: commits at this edge; no stall.
  - Result: a valid access occupies MEM_LATENCY+1 cycles and stall is high for the first MEM_LATENCY of them.
- Upstream hold: while stall=1, upstream holds EX/MEM stable (hazard unit responsibility). mem_stage does not re-sample mid-access; it uses current inputs at the commit edge.
- MEM/WB register during stall: at each edge with stall=1 it loads a bubble. All of reg_write_out, mem_to_reg_out, mem_read_data_out, alu_result_out and write_reg_out become 0.
- MEM/WB register at a commit edge, or any non-stalled edge:
  - reg_write_out <= reg_write_in & !misaligned; mem_to_reg_out <= mem_to_reg_in.
  - alu_result_out <= alu_result_in; write_reg_out <= write_reg_in.
  - mem_read_data_out <= mem[index] if mem_read_in & !misaligned, else 0.
- Store: mem[index] <= read_data2_in at the commit edge when mem_write_in & !misaligned.
- Read and write both high: the write is performed. Load data is the pre-write contents (read-before-write).
- Misaligned access:
  - No memory write, no stall, FSM stays IDLE.
  - mem_read_data_out = 0 and reg_write_out = 0.
  - misaligned is high for that cycle.
- Branch resolution:
  - pc_src = branch_in & zero_in & !stall & !reset.
  - branch_target_out = branch_target_in, combinational with zero latency.
- Reset asserted while in BUSY: the access is abandoned with no write. The FSM is in IDLE the cycle after.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W=32, REG_ADDR_W=5.
  - WORD_ALIGN_BITS=2.
  - mem_state_t enum {IDLE, BUSY}.
- One sub-module, data_memory: DEPTH_WORDS×32 array with a synchronous write port (we, index, wdata) and a combinational read port. The FSM and the MEM/WB register stay in mem_stage.

Test Plan:
1. MEM_LATENCY=0: store 0xDEADBEEF at address 0x10, then load 0x10 with reg_write=1, write_reg=8 -> at the next edge mem_read_data_out=0xDEADBEEF, write_reg_out=8, reg_write_out=1; stall never asserts.
2. MEM_LATENCY=2: load address 0x20 (contents 0x12345678) -> stall=1 for 2 cycles and the MEM/WB outputs are bubbles; on the 3rd edge mem_read_data_out=0x12345678.
3. branch_in=1, zero_in=1, target 0x00400040 -> pc_src=1 and branch_target_out=0x00400040 in the same cycle; with zero_in=0 -> pc_src=0.
4. Store to address 0x13 -> misaligned=1, memory unchanged (a subsequent load of 0x10 returns the old value), reg_write_out=0, no stall.
5. MEM_LATENCY=3: assert reset in the 2nd BUSY cycle of a store of 0xAAAA5555 to 0x40 -> all outputs 0, FSM IDLE; a later load of 0x40 returns the prior contents.
6. DEPTH_WORDS=256: store 0xCAFE0001 to 0x400, then load 0x000 -> returns 0xCAFE0001 (address wrap).
